mul_top: RTL and testbench
==========================

# mul_top

Signed integer multiplier for small operands. It takes two WIDTH-bit two's-complement operands and produces their full 2·WIDTH-bit two's-complement product on a registered output one clock after the operands are sampled. It is the top of the multiplier datapath, is fully pipelined, and accepts new operands every cycle.

## Interface
- WIDTH, default 6: operand width in bits, minimum 2. Product width is 2·WIDTH.
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- a  input  WIDTH: multiplicand, two's complement, MSB is the sign.
- b  input  WIDTH: multiplier, two's complement, MSB is the sign.
- out  output  2·WIDTH: registered product a·b, two's complement.

## Operation
- The block computes out = a × b over the full signed range [−2^(WIDTH−1), 2^(WIDTH−1)−1] for each operand.
- The result is exact. No overflow is possible: the largest magnitude, (−2^(WIDTH−1))², equals 2^(2·WIDTH−2), which fits in 2·WIDTH signed bits. For WIDTH=6, (−32)·(−32) = 1024 = 0x400.
- Negative products are sign-extended to all 2·WIDTH bits. For example, −1·1 gives 0xFFF for WIDTH=6.
- The product is formed structurally, not with the `*` operator:
  - Radix-4 Booth recoding of b produces ceil(WIDTH/2) partial products. Each is one of 0, ±a, or ±2a, sign-extended to 2·WIDTH bits.
  - The partial products are reduced with a carry-save (3:2 compressor) tree.
  - A final ripple carry-propagate adder produces the sum. Carry out of bit 2·WIDTH−1 is discarded.
- The combinational result is captured in the out register on every rising clk edge.
- There is no handshake and no enable. out always reflects the operands sampled at the previous edge.

## Timing
- Latency is 1 cycle. Operands sampled at edge N appear on out after edge N, and out holds until edge N+1.
- Throughput is one product per cycle. Back-to-back operand changes are each reflected one cycle later.
- Reset: while rst_n is low, out = 0, applied asynchronously with no clock needed. The first edge after rst_n rises loads a×b normally.
- Reset asserted mid-operation clears out immediately, and the in-flight result is lost.
- Inputs must be stable for setup/hold around the rising edge. No input registering beyond the out register.

## Structure
- Shared package mul_pkg:
  - WIDTH default.
  - PW = 2·WIDTH product-width constant.
  - NPP = (WIDTH+1)/2 partial-product count.
  - Booth digit encoding typedef: ZERO, POS1, POS2, NEG1, NEG2.
- One sub-module, booth_pp_gen: takes a and a 3-bit Booth window, and returns one sign-extended PW-bit partial product plus its negate bit.
- mul_top contains:
  - NPP instances of booth_pp_gen.
  - The carry-save tree.
  - The final adder.
  - The out register.

## Test plan
- Reset: hold rst_n low with a=5, b=7. Expect out=0 and no change on clock edges. Release reset; after one edge expect out=35 (0x023).
- Signs, WIDTH=6:
  - 3·(−4) → 0xFF4.
  - (−1)·(−1) → 0x001.
  - 0·(−31) → 0x000.
  - 31·31 → 961 (0x3C1).
  - (−31)·31 → 0xC3F.
- Extremes: (−32)·(−32) → 0x400. (−32)·31 → 0xC20. (−32)·1 → 0xFE0.
- Exhaustive: all 4096 (a, b) pairs applied one per cycle. Each out equals (a·b) mod 4096 exactly one cycle later; zero mismatches.
- Pipelining: change operands every cycle through 2·3, −2·3, 5·−5. Expect 0x006, 0xFFA, 0xFE7 on consecutive cycles.
- Async reset mid-stream: drop rst_n between edges. out goes to 0 before the next edge and resumes products after release.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants, Booth digit encoding and elaboration-time helpers for the
// signed radix-4 Booth multiplier datapath.
package mul_pkg;

    localparam int WIDTH = 6;
    localparam int PW    = 2 * WIDTH;
    localparam int NPP   = (WIDTH + 1) / 2;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_t;

    function automatic int pw_of(input int w);
        return 2 * w;
    endfunction

    function automatic int npp_of(input int w);
        return (w + 1) / 2;
    endfunction

    // Rows left after one layer of 3:2 compressors: each full triple becomes two.
    function automatic int csa_next(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int csa_count_at(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) c = csa_next(c);
        return c;
    endfunction

    function automatic int csa_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        for (int i = 0; i < 64; i++) begin
            if (c > 2) begin
                c = csa_next(c);
                l++;
            end
        end
        return l;
    endfunction

    function automatic booth_t booth_decode(input logic [2:0] win);
        booth_t d;
        case (win)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: selects 0, a or 2a, inverted when the digit
// is negative; the +1 that completes the negation is returned as neg_o.
module booth_pp_gen #(
    parameter int WIDTH = 6,
    parameter int PW    = 12
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [2:0]       win_i,
    output logic [PW-1:0]    pp_o,
    output logic             neg_o
);
    import mul_pkg::*;

    booth_t                  dig;
    logic signed [WIDTH-1:0] a_s;
    logic signed [PW-1:0]    a_ext;
    logic signed [PW-1:0]    mag;

    assign dig   = booth_decode(win_i);
    assign a_s   = a_i;
    assign a_ext = PW'(a_s);

    always_comb begin
        mag = '0;
        case (dig)
            POS1, NEG1: mag = a_ext;
            POS2, NEG2: mag = a_ext <<< 1;
            default:    mag = '0;
        endcase
    end

    assign neg_o = (dig == NEG1) || (dig == NEG2);
    assign pp_o  = neg_o ? ~mag : mag;

endmodule

// File: rtl/mul_top.sv
// Signed WIDTH x WIDTH multiplier: Booth partial products, carry-save reduction,
// ripple carry-propagate adder, registered 2*WIDTH-bit product (latency 1).
module mul_top #(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] out
);
    import mul_pkg::*;

    localparam int PROD_W = pw_of(WIDTH);
    localparam int NPP_N  = npp_of(WIDTH);
    localparam int NR     = NPP_N + 1;
    localparam int NLV    = csa_levels(NR);

    logic signed [WIDTH-1:0]   b_s;
    logic signed [2*NPP_N-1:0] b_ext;
    logic [2*NPP_N:0]          bx;
    logic [PROD_W-1:0]         pp [NPP_N];
    logic [NPP_N-1:0]          neg;
    logic [PROD_W-1:0]         negv;
    logic [PROD_W-1:0]         rows [NR];
    logic [PROD_W-1:0]         sum_v;
    logic [PROD_W-1:0]         cry_v;
    logic [PROD_W-1:0]         out_d;
    logic [PROD_W-1:0]         out_q;

    // Implicit zero below bit 0 of b; odd widths get one extra sign bit on top.
    assign b_s   = b;
    assign b_ext = (2*NPP_N)'(b_s);
    assign bx    = {b_ext, 1'b0};

    for (genvar i = 0; i < NPP_N; i++) begin : g_pp
        booth_pp_gen #(
            .WIDTH(WIDTH),
            .PW   (PROD_W)
        ) u_pp (
            .a_i  (a),
            .win_i(bx[2*i+2 -: 3]),
            .pp_o (pp[i]),
            .neg_o(neg[i])
        );
        assign rows[i] = pp[i] << (2 * i);
    end

    always_comb begin
        negv = '0;
        for (int i = 0; i < NPP_N; i++) negv[2*i] = neg[i];
    end
    assign rows[NPP_N] = negv;

    if (NLV == 0) begin : g_flat
        assign sum_v = rows[0];
        assign cry_v = rows[1];
    end else begin : g_tree
        for (genvar L = 0; L < NLV; L++) begin : g_lv
            localparam int N  = csa_count_at(NR, L);
            localparam int G  = N / 3;
            localparam int NN = csa_next(N);
            logic [PROD_W-1:0] cur [N];
            logic [PROD_W-1:0] nxt [NN];

            if (L == 0) begin : g_src
                assign cur = rows;
            end else begin : g_src
                assign cur = g_lv[L-1].nxt;
            end

            for (genvar j = 0; j < G; j++) begin : g_csa
                assign nxt[2*j]   = cur[3*j] ^ cur[3*j+1] ^ cur[3*j+2];
                assign nxt[2*j+1] = ((cur[3*j] & cur[3*j+1]) | (cur[3*j] & cur[3*j+2])
                                   | (cur[3*j+1] & cur[3*j+2])) << 1;
            end
            for (genvar r = 0; r < N - 3*G; r++) begin : g_pass
                assign nxt[2*G+r] = cur[3*G+r];
            end
        end
        assign sum_v = g_lv[NLV-1].nxt[0];
        assign cry_v = g_lv[NLV-1].nxt[1];
    end

    // Carry out of the MSB is dropped; the product always fits in PROD_W bits.
    always_comb begin
        logic carry;
        carry = 1'b0;
        out_d = '0;
        for (int i = 0; i < PROD_W; i++) begin
            out_d[i] = sum_v[i] ^ cry_v[i] ^ carry;
            carry    = (sum_v[i] & cry_v[i]) | (carry & (sum_v[i] ^ cry_v[i]));
        end
    end

    // Stage boundary: product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_mul_top.sv
// Self-checking bench for mul_top (WIDTH=6): directed sign/extreme cases,
// exhaustive and random operand sweeps, pipelining and async reset behaviour.
module tb_mul_top;
    localparam int W  = 6;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] out;

    int vectors;
    int errors;

    int          sg_a   [5] = '{3, -1, 0, 31, -31};
    int          sg_b   [5] = '{-4, -1, -31, 31, 31};
    logic [11:0] sg_exp [5] = '{12'hFF4, 12'h001, 12'h000, 12'h3C1, 12'hC3F};
    int          ex_a   [3] = '{-32, -32, -32};
    int          ex_b   [3] = '{-32, 31, 1};
    logic [11:0] ex_exp [3] = '{12'h400, 12'hC20, 12'hFE0};

    mul_top #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_int(input logic [W-1:0] x);
        return x[W-1] ? int'(x) - (1 << W) : int'(x);
    endfunction

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        return PW'(to_int(x) * to_int(y));
    endfunction

    task automatic apply(input int av, input int bv);
        @(negedge clk);
        a = W'(av);
        b = W'(bv);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = W'(5);
        b = W'(7);
        #2;
        vectors++;
        if (out !== '0) begin
            errors++;
            $display("FAIL reset_async: out=%h expected %h", out, 12'h000);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out !== '0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: out=%h expected %h", i, out, 12'h000);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (out !== 12'h023) begin
            errors++;
            $display("FAIL reset_release: out=%h expected %h", out, 12'h023);
        end
    endtask

    task automatic test_signs();
        for (int i = 0; i < 5; i++) begin
            apply(sg_a[i], sg_b[i]);
            vectors++;
            if (out !== sg_exp[i]) begin
                errors++;
                $display("FAIL signs %0d*%0d: out=%h expected %h", sg_a[i], sg_b[i], out, sg_exp[i]);
            end
        end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 3; i++) begin
            apply(ex_a[i], ex_b[i]);
            vectors++;
            if (out !== ex_exp[i]) begin
                errors++;
                $display("FAIL extreme %0d*%0d: out=%h expected %h", ex_a[i], ex_b[i], out, ex_exp[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [PW-1:0] exp_v;
        for (int ai = 0; ai < (1 << W); ai++) begin
            for (int bi = 0; bi < (1 << W); bi++) begin
                apply(ai, bi);
                exp_v = ref_mul(W'(ai), W'(bi));
                vectors++;
                if (out !== exp_v) begin
                    errors++;
                    $display("FAIL exhaustive a=%h b=%h: out=%h expected %h", W'(ai), W'(bi), out, exp_v);
                end
            end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic [PW-1:0] exp_v;
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            apply(int'(ra), int'(rb));
            exp_v = ref_mul(ra, rb);
            vectors++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL random a=%h b=%h: out=%h expected %h", ra, rb, out, exp_v);
            end
        end
    endtask

    task automatic test_pipeline();
        apply(2, 3);
        vectors++;
        if (out !== 12'h006) begin
            errors++;
            $display("FAIL pipe0: out=%h expected %h", out, 12'h006);
        end
        apply(-2, 3);
        vectors++;
        if (out !== 12'hFFA) begin
            errors++;
            $display("FAIL pipe1: out=%h expected %h", out, 12'hFFA);
        end
        apply(5, -5);
        vectors++;
        if (out !== 12'hFE7) begin
            errors++;
            $display("FAIL pipe2: out=%h expected %h", out, 12'hFE7);
        end
    endtask

    task automatic test_async_reset();
        apply(13, -9);
        vectors++;
        if (out !== ref_mul(W'(13), W'(-9))) begin
            errors++;
            $display("FAIL async_pre: out=%h expected %h", out, ref_mul(W'(13), W'(-9)));
        end
        @(negedge clk);
        a = W'(7);
        b = W'(7);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out !== '0) begin
            errors++;
            $display("FAIL async_drop: out=%h expected %h", out, 12'h000);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out !== '0) begin
            errors++;
            $display("FAIL async_held: out=%h expected %h", out, 12'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (out !== ref_mul(W'(7), W'(7))) begin
            errors++;
            $display("FAIL async_resume: out=%h expected %h", out, ref_mul(W'(7), W'(7)));
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        a = '0;
        b = '0;
        rst_n = 1'b0;
        test_reset();
        test_signs();
        test_extremes();
        test_exhaustive();
        test_random_back_to_back();
        test_pipeline();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
